// File: rtl/delay_pulse_monitor.sv
// Receive-side period checker for the DELAY strobe: flags early/late pulses and reports lock.
// Optional statistics counter (err_cnt) is enabled by defining DELAY_MON_STATS_EN.
module delay_pulse_monitor #(
  parameter int N        = 1250,
  parameter int CBITS    = 11,
  parameter int TOL      = 0,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig,
  input  logic             clr,
  output logic             lock,
  output logic             early_err,
  output logic             late_err,
  output logic             err_sticky,
  output logic [CBITS-1:0] period
`ifdef DELAY_MON_STATS_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  if (N + TOL + 1 > (2 ** CBITS) - 1) begin : g_cbits_chk
    $error("CBITS too small to hold N+TOL+1");
  end
  if (TOL > N) begin : g_tol_chk
    $error("TOL must not exceed N");
  end
  if (LOCK_CNT < 1 || LOCK_CNT > 15) begin : g_lock_chk
    $error("LOCK_CNT must be in 1..15");
  end

  localparam logic [CBITS-1:0] LO_C   = CBITS'(N - TOL);
  localparam logic [CBITS-1:0] LATE_C = CBITS'(N + TOL + 1);
  localparam logic [3:0]       LOCK_C = 4'(LOCK_CNT);

  typedef enum logic [1:0] {HUNT, TRACK, LOCKED} state_t;

  function automatic logic [CBITS-1:0] sat_inc(input logic [CBITS-1:0] v);
    return (&v) ? v : v + CBITS'(1);
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] v, input logic inc);
    return (inc && v != 8'hFF) ? v + 8'd1 : v;
  endfunction

  state_t           state, state_nxt;
  logic [CBITS-1:0] cnt;
  logic [3:0]       good, good_nxt;
  logic [CBITS-1:0] period_nxt;
  logic             early_nxt, late_nxt;

  always_comb begin
    state_nxt  = state;
    good_nxt   = good;
    period_nxt = period;
    early_nxt  = 1'b0;
    late_nxt   = 1'b0;
    case (state)
      HUNT: begin
        if (sig) begin
          state_nxt = TRACK;
          good_nxt  = 4'd0;
        end
      end
      TRACK, LOCKED: begin
        // The late point wins over a coincident sig, which then becomes the new reference.
        if (cnt == LATE_C) begin
          late_nxt  = 1'b1;
          good_nxt  = 4'd0;
          state_nxt = sig ? TRACK : HUNT;
        end else if (sig) begin
          period_nxt = cnt;
          if (cnt < LO_C) begin
            early_nxt = 1'b1;
            good_nxt  = 4'd0;
            state_nxt = TRACK;
          end else begin
            if (good < LOCK_C) good_nxt = good + 4'd1;
            if (good_nxt == LOCK_C) state_nxt = LOCKED;
          end
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  // Registered state, gap counter and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      cnt        <= '0;
      good       <= 4'd0;
      period     <= '0;
      lock       <= 1'b0;
      early_err  <= 1'b0;
      late_err   <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= sig ? '0 : sat_inc(cnt);
      good       <= good_nxt;
      period     <= period_nxt;
      lock       <= (state_nxt == LOCKED);
      early_err  <= early_nxt;
      late_err   <= late_nxt;
      // Held through the pulse cycle so a clr coinciding with the pulse cannot lose it.
      err_sticky <= early_nxt | late_nxt | early_err | late_err | (err_sticky & ~clr);
    end
  end

`ifdef DELAY_MON_STATS_EN
  // Counts the registered pulses, so clr in the pulse cycle leaves exactly that event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 8'd0;
    end else if (clr) begin
      err_cnt <= {7'd0, early_err | late_err};
    end else begin
      err_cnt <= sat_add8(err_cnt, early_err | late_err);
    end
  end
`endif

endmodule

// File: tb/tb_delay_pulse_monitor.sv
// Bench for delay_pulse_monitor: directed scenarios plus randomized gaps against a timestamp model.
module tb_delay_pulse_monitor;
  localparam int N    = 1250;
  localparam int TOL  = 2;
  localparam int LOCK = 4;
  localparam int CB   = 11;
  localparam int MAXC = 2047;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sig = 1'b0;
  logic          clr = 1'b0;
  logic          lock, early_err, late_err, err_sticky;
  logic [CB-1:0] period;
`ifdef DELAY_MON_STATS_EN
  logic [7:0]    err_cnt;
`endif

  delay_pulse_monitor #(.N(N), .CBITS(CB), .TOL(TOL), .LOCK_CNT(LOCK)) dut (
    .clk(clk), .rst_n(rst_n), .sig(sig), .clr(clr),
    .lock(lock), .early_err(early_err), .late_err(late_err),
    .err_sticky(err_sticky), .period(period)
`ifdef DELAY_MON_STATS_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model: pulse timestamps and a mode (0 hunt, 1 track, 2 locked).
  int cyc = 0, last_ev = 0, mode = 0, good = 0;
  int m_period = 0, m_early = 0, m_late = 0, m_sticky = 0, m_ecnt = 0;

  task automatic model(input bit s, input bit c);
    int cv;
    int old_pulse;
    old_pulse = m_early | m_late;
    cyc++;
    cv = cyc - last_ev - 1;
    if (cv > MAXC) cv = MAXC;
    m_early = 0;
    m_late  = 0;
    if (mode == 0) begin
      if (s) begin mode = 1; good = 0; end
    end else if (cv == N + TOL + 1) begin
      m_late = 1; good = 0; mode = s ? 1 : 0;
    end else if (s) begin
      m_period = cv;
      if (cv < N - TOL) begin
        m_early = 1; good = 0; mode = 1;
      end else begin
        good++;
        if (good >= LOCK) mode = 2;
      end
    end
    if (s) last_ev = cyc;
    m_sticky = (m_early | m_late | old_pulse | (m_sticky & !c)) ? 1 : 0;
    if (c) m_ecnt = old_pulse;
    else if (old_pulse != 0 && m_ecnt < 255) m_ecnt++;
  endtask

  task automatic check_all();
    chk("lock", lock, (mode == 2) ? 1 : 0);
    chk("early_err", early_err, m_early);
    chk("late_err", late_err, m_late);
    chk("err_sticky", err_sticky, m_sticky);
    chk("period", period, m_period);
`ifdef DELAY_MON_STATS_EN
    chk("err_cnt", err_cnt, m_ecnt);
`endif
  endtask

  task automatic step(input bit s, input bit c);
    sig = s;
    clr = c;
    @(posedge clk);
    model(s, c);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n, input bit rclr);
    for (int i = 0; i < n; i++) step(1'b0, rclr && ($urandom_range(0, 63) == 0));
  endtask

  // Pulse arriving when the gap counter reads cv.
  task automatic pulse_at(input int cv);
    idle(cv, 1'b0);
    step(1'b1, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    sig = 1'b0;
    clr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_lock", lock, 0);
    chk("rst_early", early_err, 0);
    chk("rst_late", late_err, 0);
    chk("rst_sticky", err_sticky, 0);
    chk("rst_period", period, 0);
`ifdef DELAY_MON_STATS_EN
    chk("rst_err_cnt", err_cnt, 0);
`endif
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mode = 0; good = 0; m_period = 0; m_early = 0; m_late = 0;
    m_sticky = 0; m_ecnt = 0; last_ev = cyc;
  endtask

  initial begin
    int waited;
    // 1: lock after the 5th pulse
    do_reset();
    step(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      pulse_at(N);
      if (i == 3) chk("t1_lock", lock, 1);
    end
    chk("t1_period", period, N);

    // 2: early pulse while locked, then relock
    pulse_at(1246);
    chk("t2_early", early_err, 1);
    chk("t2_lock", lock, 0);
    chk("t2_sticky", err_sticky, 1);
    chk("t2_period", period, 1246);
    for (int i = 0; i < 4; i++) pulse_at(N);
    chk("t2_relock", lock, 1);

    // 3: strobe stops
    idle(N + TOL + 2, 1'b0);
    chk("t3_late", late_err, 1);
    chk("t3_lock", lock, 0);
    idle(10000, 1'b0);

    // 4: band edges, then sig in the late cycle
    step(1'b1, 1'b0);
    pulse_at(N - TOL);
    pulse_at(N + TOL);
    chk("t4_edge_ok", early_err | late_err, 0);
    pulse_at(N + TOL + 1);
    chk("t4_late", late_err, 1);
    pulse_at(N);
    chk("t4_track", late_err | early_err, 0);

    // 5: reset in the middle of LOCKED
    for (int i = 0; i < 3; i++) pulse_at(N);
    chk("t5_locked", lock, 1);
    idle(100, 1'b0);
    do_reset();
    step(1'b1, 1'b0);
    chk("t5_first", early_err | late_err, 0);

    // 6: clr coinciding with a late_err pulse, then error counter saturation
    for (int i = 0; i < 4; i++) pulse_at(N);
    step(1'b0, 1'b1);
    chk("t6_cleared", err_sticky, 0);
    waited = 0;
    while (late_err !== 1'b1 && waited < 2000) begin
      step(1'b0, 1'b0);
      waited++;
    end
    chk("t6_timeout", (waited < 2000) ? 1 : 0, 1);
    step(1'b0, 1'b1);
    chk("t6_sticky", err_sticky, 1);
`ifdef DELAY_MON_STATS_EN
    chk("t6_err_cnt1", err_cnt, 1);
`endif
    for (int i = 0; i < 301; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
`ifdef DELAY_MON_STATS_EN
    chk("t6_err_cnt255", err_cnt, 255);
`endif

    // Randomized gaps, bursts and clears
    do_reset();
    step(1'b1, 1'b0);
    for (int it = 0; it < 16; it++) begin
      int unsigned kind;
      kind = $urandom_range(0, 9);
      if (kind <= 5) begin
        idle(int'($urandom_range(N - TOL - 2, N + TOL)), 1'b1);
        step(1'b1, 1'b0);
      end else if (kind == 6) begin
        idle(int'($urandom_range(0, N - TOL - 1)), 1'b1);
        step(1'b1, 1'b0);
      end else if (kind == 7) begin
        idle(N + TOL + 2 + int'($urandom_range(0, 50)), 1'b1);
        step(1'b1, 1'b0);
      end else if (kind == 8) begin
        idle(N, 1'b1);
        for (int k = 0; k < int'($urandom_range(1, 4)); k++) step(1'b1, 1'b0);
      end else begin
        pulse_at(N + TOL + 1);
      end
    end
    idle(20, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
